ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 12, meaning RAM address width.
REQ-002 SHALL have parameter DW, default 16, meaning RAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports m0_req / m1_req  input  1  access request from requester 0 / 1.
REQ-006 SHALL have ports m0_we / m1_we  input  1  1 = write, 0 = read; valid while req=1.
REQ-007 SHALL have ports m0_addr / m1_addr  input  AW  access address; valid while req=1.
REQ-008 SHALL have ports m0_wdata / m1_wdata  input  DW  write data; valid while req=1 and we=1.
REQ-009 SHALL have ports m0_gnt / m1_gnt  output  1  one-cycle pulse: the request is being issued to RAM this cycle.
REQ-010 SHALL have ports m0_rvalid / m1_rvalid  output  1  one-cycle pulse: rdata holds the completed read.
REQ-011 SHALL have ports m0_rdata / m1_rdata  output  DW  read result, held until that port's next read completes.
REQ-012 SHALL have ports ram_addr  output  AW, ram_data_in  output  DW, ram_we  output  1, ram_re  output  1  RAM command bus.
REQ-013 SHALL have port ram_data_out  input  DW  RAM read data, registered by the RAM on the clk edge where ram_re=1.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, CMD, RESP.
REQ-015 SHALL sample m0_req/m1_req only in IDLE; if no request is active, SHALL stay in IDLE.
REQ-016 SHALL use round-robin arbitration with a last-grant pointer: a single active requester wins; if both are active, the port not granted last wins.
REQ-017 SHALL update the last-grant pointer on every IDLE->CMD transition.
REQ-018 SHALL, on IDLE->CMD, register the winner's addr, wdata and we onto ram_addr, ram_data_in and a one-cycle ram_we (we=1) or ram_re (we=0) strobe that is asserted only during CMD.
REQ-019 SHALL assert the winner's gnt only during the CMD cycle; exactly one gnt is high at any time.
REQ-020 SHALL transition CMD->IDLE for writes and CMD->RESP for reads.
REQ-021 SHALL, in RESP, capture ram_data_out into the granted port's rdata at the end of the cycle, pulse that port's rvalid in the following cycle, and return to IDLE.
REQ-022 SHALL give a read latency of req sampled at cycle 0 -> gnt at cycle 1 -> RESP at cycle 2 -> rvalid at cycle 3. A write issues in cycle 1 and the block is back in IDLE at cycle 2.
REQ-023 SHALL never assert ram_we and ram_re together; both SHALL be 0 outside CMD.
REQ-024 SHALL hold ram_addr and ram_data_in at their last issued values outside CMD.
REQ-025 Requesters SHALL hold req, we, addr and wdata stable until gnt. A req still high in the cycle after gnt SHALL be treated as a new request.
REQ-026 SHALL never modify the rdata of the non-granted port.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronously), force state IDLE, last-grant pointer = port 1 (so port 0 wins the first contention), all gnt/rvalid/ram_we/ram_re = 0, and ram_addr, ram_data_in, m0_rdata, m1_rdata = 0.
REQ-028 SHALL abort an in-flight access on reset: no gnt or rvalid is produced for it after rst_n rises.
REQ-029 SHALL sample requests again from the first rising clk edge after rst_n deasserts.

Verification
REQ-030 Single write/read: m0 writes 0x000=0xA5A5, then reads 0x000 -> ram_we in cycle 1; read gives m0_rvalid at cycle 3 with m0_rdata=0xA5A5.
REQ-031 Contention after reset: m0 and m1 both request reads the same cycle -> m0_gnt first, m1_gnt at the next IDLE->CMD, and each rdata matches its own address.
REQ-032 Round-robin fairness: both ports hold req continuously for 8 accesses -> grants alternate 0,1,0,1..., with no port granted twice in a row.
REQ-033 Interleaved read/write: m0 writes 0x001=0x5A5A while m1 reads 0x001 (m0 wins) -> m1_rdata=0x5A5A, m0_rdata unchanged.
REQ-034 Reset mid-read: rst_n driven low during RESP -> all outputs 0 immediately, no rvalid after release, and the next request is served normally.
REQ-035 Strobe checks: an assertion across all tests that ram_we&ram_re is never 1, at most one gnt is high, and strobes appear only in CMD.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter in front of a single-port synchronous RAM
module ram_arbiter #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [DW-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          sel_q, sel_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          rv0_q, rv0_d, rv1_q, rv1_d;
    logic          we_q, we_d, re_q, re_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic          win;
    logic          win_we;

    // Under contention the port not granted last wins; a lone requester always wins.
    assign win    = (m0_req && m1_req) ? ~last_q : m1_req;
    assign win_we = win ? m1_we : m0_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            we_q    <= we_d;
            re_q    <= re_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = CMD;
                    last_d  = win;
                    sel_d   = win;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    addr_d  = win ? m1_addr : m0_addr;
                    din_d   = win ? m1_wdata : m0_wdata;
                    we_d    = win_we;
                    re_d    = ~win_we;
                end
            end
            CMD: begin
                state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                // RAM registered the read on the CMD edge, so data is valid now.
                if (sel_q) begin
                    rd1_d = ram_data_out;
                    rv1_d = 1'b1;
                end else begin
                    rd0_d = ram_data_out;
                    rv0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0_gnt      = gnt0_q;
    assign m1_gnt      = gnt1_q;
    assign m0_rvalid   = rv0_q;
    assign m1_rvalid   = rv1_q;
    assign m0_rdata    = rd0_q;
    assign m1_rdata    = rd1_q;
    assign ram_addr    = addr_q;
    assign ram_data_in = din_q;
    assign ram_we      = we_q;
    assign ram_re      = re_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in, ram_data_out;
    logic          ram_we, ram_re;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we), .ram_re(ram_re),
        .ram_data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM; contents reload to addr ^ 0x1234 while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 16'(i) ^ 16'h1234;
            ram_data_out <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_data_in;
            if (ram_re) ram_data_out <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("excl", 32'(ram_we & ram_re), 32'd0);
        chk("onegnt", 32'(m0_gnt & m1_gnt), 32'd0);
        chk("strb_in_cmd", 32'(ram_we | ram_re), 32'(m0_gnt | m1_gnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 32'({m0_gnt, m1_gnt}), 32'd0);
        chk({tag, "_rv"}, 32'({m0_rvalid, m1_rvalid}), 32'd0);
        chk({tag, "_strb"}, 32'({ram_we, ram_re}), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_din"}, 32'(ram_data_in), 32'd0);
        chk({tag, "_rd0"}, 32'(m0_rdata), 32'd0);
        chk({tag, "_rd1"}, 32'(m1_rdata), 32'd0);
    endtask

    int     n;
    logic   seq [0:7];

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        tick();
        tick();
        chk_zero("rst");
        rst_n = 1'b1;

        // single write then read on port 0
        m0_we = 1; m0_addr = 12'h000; m0_wdata = 16'hA5A5; m0_req = 1;
        tick();
        chk("w_gnt", 32'(m0_gnt), 1);
        chk("w_we", 32'(ram_we), 1);
        chk("w_addr", 32'(ram_addr), 32'h000);
        chk("w_din", 32'(ram_data_in), 32'hA5A5);
        m0_req = 0;
        tick();
        chk("w_idle_strb", 32'(ram_we), 0);
        chk("w_hold_din", 32'(ram_data_in), 32'hA5A5);
        m0_we = 0; m0_req = 1;
        tick();
        chk("r_gnt", 32'(m0_gnt), 1);
        chk("r_re", 32'(ram_re), 1);
        m0_req = 0;
        tick();
        chk("r_rv_early", 32'(m0_rvalid), 0);
        tick();
        chk("r_rv", 32'(m0_rvalid), 1);
        chk("r_data", 32'(m0_rdata), 32'hA5A5);
        chk("r_rv1", 32'(m1_rvalid), 0);
        tick();
        chk("r_rv_pulse", 32'(m0_rvalid), 0);
        chk("r_hold", 32'(m0_rdata), 32'hA5A5);

        // contention right after reset: port 0 first
        do_reset();
        m0_we = 0; m0_addr = 12'h010; m0_req = 1;
        m1_we = 0; m1_addr = 12'h020; m1_req = 1;
        tick();
        chk("c_gnt0", 32'({m0_gnt, m1_gnt}), 32'b10);
        chk("c_addr0", 32'(ram_addr), 32'h010);
        m0_req = 0;
        tick();
        tick();
        chk("c_rv0", 32'(m0_rvalid), 1);
        chk("c_rd0", 32'(m0_rdata), 32'h1224);
        tick();
        chk("c_gnt1", 32'({m0_gnt, m1_gnt}), 32'b01);
        chk("c_addr1", 32'(ram_addr), 32'h020);
        m1_req = 0;
        tick();
        tick();
        chk("c_rv1", 32'(m1_rvalid), 1);
        chk("c_rd1", 32'(m1_rdata), 32'h1214);
        chk("c_rd0_keep", 32'(m0_rdata), 32'h1224);

        // m0 write and m1 read of the same address; m0 wins since m1 was last
        m0_we = 1; m0_addr = 12'h001; m0_wdata = 16'h5A5A; m0_req = 1;
        m1_we = 0; m1_addr = 12'h001; m1_req = 1;
        tick();
        chk("i_gnt0", 32'({m0_gnt, m1_gnt}), 32'b10);
        chk("i_we", 32'(ram_we), 1);
        m0_req = 0;
        tick();
        tick();
        chk("i_gnt1", 32'({m0_gnt, m1_gnt}), 32'b01);
        chk("i_re", 32'(ram_re), 1);
        m1_req = 0;
        tick();
        tick();
        chk("i_rv1", 32'(m1_rvalid), 1);
        chk("i_rd1", 32'(m1_rdata), 32'h5A5A);
        chk("i_rd0_keep", 32'(m0_rdata), 32'h1224);

        // round-robin with both requesting writes continuously
        do_reset();
        m0_we = 1; m0_addr = 12'h100; m0_wdata = 16'h1111; m0_req = 1;
        m1_we = 1; m1_addr = 12'h200; m1_wdata = 16'h2222; m1_req = 1;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            tick();
            if (m0_gnt) begin seq[n] = 1'b0; n++; end
            else if (m1_gnt) begin seq[n] = 1'b1; n++; end
        end
        m0_req = 0; m1_req = 0;
        chk("rr_cnt", 32'(n), 8);
        for (int k = 0; k < 8; k++) chk("rr_seq", 32'(seq[k]), 32'(k % 2));
        tick();

        // reset while a read is in RESP
        m0_we = 0; m0_addr = 12'h010; m0_req = 1;
        tick();
        chk("m_gnt", 32'(m0_gnt), 1);
        m0_req = 0;
        tick();
        rst_n = 1'b0;
        #1;
        chk_zero("mrst");
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("m_no_rv", 32'({m0_rvalid, m1_rvalid, m0_gnt, m1_gnt}), 0);
        end
        m1_we = 0; m1_addr = 12'h020; m1_req = 1;
        tick();
        chk("m_gnt1", 32'({m0_gnt, m1_gnt}), 32'b01);
        m1_req = 0;
        tick();
        tick();
        chk("m_rv1", 32'(m1_rvalid), 1);
        chk("m_rd1", 32'(m1_rdata), 32'h1214);
        chk("m_rd0", 32'(m0_rdata), 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
